// File: rtl/btb_write_scheduler_pkg.sv
// Shared types and constants for the AXBTB write scheduler: entry/index types,
// deferred-write queue payload, FSM state encoding and the bank-select helper.
package btb_write_scheduler_pkg;

  localparam int AXBTB_INDEX_W  = 10;
  localparam int AXBTB_BANK_NUM = 2;
  localparam int BTB_WQ_DEPTH   = 4;

  typedef logic [AXBTB_INDEX_W-1:0] AXBTB_IndexPath;

  typedef struct packed {
    logic        valid;
    logic [15:0] tag;
    logic [31:0] target;
  } AXBTB_Entry;

  typedef struct packed {
    AXBTB_IndexPath index;
    AXBTB_Entry     entry;
  } btb_wq_entry_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_FLUSH
  } btb_ws_state_e;

  function automatic int unsigned bank_of(input AXBTB_IndexPath idx, input int unsigned banks);
    return 32'(idx) % banks;
  endfunction

endpackage

// File: rtl/btb_write_scheduler_if.sv
// Requester and RAM write-port bundle of the AXBTB write scheduler.
// master = requester/RAM side, slave = scheduler side.
interface btb_write_scheduler_if #(
  parameter int WRITE_NUM = 2
);
  import btb_write_scheduler_pkg::*;

  logic [WRITE_NUM-1:0] reqValid;
  AXBTB_IndexPath       reqIndex [WRITE_NUM];
  AXBTB_Entry           reqEntry [WRITE_NUM];
  logic [WRITE_NUM-1:0] ramWe;
  AXBTB_IndexPath       ramWa [WRITE_NUM];
  AXBTB_Entry           ramWv [WRITE_NUM];

  modport master (
    output reqValid, reqIndex, reqEntry,
    input  ramWe, ramWa, ramWv
  );

  modport slave (
    input  reqValid, reqIndex, reqEntry,
    output ramWe, ramWa, ramWv
  );

endinterface

// File: rtl/btb_write_scheduler_qptr.sv
// Head/tail pointer pair for the deferred-write queue; an extra wrap bit on
// each pointer distinguishes full from empty.
module btb_write_scheduler_qptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH)-1:0] tail,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] head_q;
  logic [AW:0] tail_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  assign head  = head_q[AW-1:0];
  assign tail  = tail_q[AW-1:0];
  assign count = tail_q - head_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/btb_write_scheduler.sv
// AXBTB write scheduler: initial/flush invalidate sweep, then per-cycle
// bank-conflict arbitration of write requests with a small coalescing queue.
module btb_write_scheduler
  import btb_write_scheduler_pkg::*;
#(
  parameter int ENTRY_NUM   = 1024,
  parameter int WRITE_NUM   = 2,
  parameter int BANK_NUM    = AXBTB_BANK_NUM,
  parameter int QUEUE_DEPTH = BTB_WQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  btb_write_scheduler_if.slave   bus,
  input  logic                   flushReq,
  output logic                   initDone,
  output logic                   queueFull,
  output logic [15:0]            dropCount
);
  localparam int QAW = $clog2(QUEUE_DEPTH);
  localparam int DW  = $clog2(WRITE_NUM + 1);

  btb_ws_state_e  state;
  btb_ws_state_e  next_state;
  AXBTB_IndexPath sweep_index;

  btb_wq_entry_t  queue      [QUEUE_DEPTH];
  btb_wq_entry_t  queue_next [QUEUE_DEPTH];
  btb_wq_entry_t  push_data;
  btb_wq_entry_t  head_entry;
  logic [QUEUE_DEPTH-1:0] occupied;

  logic [QAW-1:0] head;
  logic [QAW-1:0] tail;
  logic [QAW:0]   count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           clear;

  logic [WRITE_NUM-1:0] we;
  AXBTB_IndexPath       wa [WRITE_NUM];
  AXBTB_Entry           wv [WRITE_NUM];
  logic [WRITE_NUM-1:0] coal;
  logic [WRITE_NUM-1:0] direct;
  logic                 lose;
  logic                 loser_found;
  logic                 pop_port_found;
  int unsigned          pop_port;
  logic                 head_conflict;

  logic [DW-1:0] drop_n;
  logic [15:0]   drop_count;
  logic [16:0]   drop_sum;

  logic sweeping;
  logic run_active;

  assign sweeping   = rst_n && (state != ST_RUN);
  assign run_active = rst_n && (state == ST_RUN) && !flushReq;
  assign clear      = (state == ST_RUN) && flushReq;

  always_comb begin
    next_state = state;
    unique case (state)
      ST_INIT, ST_FLUSH: if (sweep_index == AXBTB_IndexPath'(ENTRY_NUM - 1)) next_state = ST_RUN;
      ST_RUN:            if (flushReq) next_state = ST_FLUSH;
      default:           next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      sweep_index <= '0;
    end else begin
      state <= next_state;
      if (state != ST_RUN && next_state != ST_RUN) sweep_index <= sweep_index + 1'b1;
      else                                         sweep_index <= '0;
    end
  end

  btb_write_scheduler_qptr #(
    .DEPTH (QUEUE_DEPTH)
  ) queue_pointer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .head  (head),
    .tail  (tail),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  for (genvar s = 0; s < QUEUE_DEPTH; s++) begin : g_occ
    assign occupied[s] = ({1'b0, QAW'(s) - head} < count);
  end

  always_comb begin
    we             = '0;
    for (int unsigned p = 0; p < WRITE_NUM; p++) begin
      wa[p] = '0;
      wv[p] = '0;
    end
    queue_next     = queue;
    push_data      = '0;
    head_entry     = '0;
    coal           = '0;
    direct         = '0;
    lose           = 1'b0;
    loser_found    = 1'b0;
    pop_port_found = 1'b0;
    pop_port       = 0;
    head_conflict  = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    drop_n         = '0;

    if (sweeping) begin
      we[0] = 1'b1;
      wa[0] = sweep_index;
    end else if (run_active) begin
      // Ascending port order: a younger request coalescing into the same slot wins.
      for (int unsigned p = 0; p < WRITE_NUM; p++) begin
        if (bus.reqValid[p]) begin
          for (int unsigned s = 0; s < QUEUE_DEPTH; s++) begin
            if (occupied[s] && queue[s].index == bus.reqIndex[p]) begin
              queue_next[s].entry = bus.reqEntry[p];
              coal[p]             = 1'b1;
            end
          end
        end
      end

      for (int unsigned p = 0; p < WRITE_NUM; p++) begin
        if (bus.reqValid[p] && !coal[p]) begin
          lose = 1'b0;
          for (int unsigned q = 0; q < p; q++) begin
            if (direct[q] && bank_of(bus.reqIndex[q], BANK_NUM) == bank_of(bus.reqIndex[p], BANK_NUM))
              lose = 1'b1;
          end
          if (!lose) begin
            direct[p] = 1'b1;
            we[p]     = 1'b1;
            wa[p]     = bus.reqIndex[p];
            wv[p]     = bus.reqEntry[p];
          end else if (!loser_found) begin
            loser_found = 1'b1;
            push_data   = '{index: bus.reqIndex[p], entry: bus.reqEntry[p]};
          end else begin
            drop_n = drop_n + 1'b1;
          end
        end
      end

      // The head is read after coalescing so a same-cycle update is not lost on pop.
      head_entry = queue_next[head];
      for (int unsigned p = 0; p < WRITE_NUM; p++) begin
        if (direct[p] && bank_of(bus.reqIndex[p], BANK_NUM) == bank_of(head_entry.index, BANK_NUM))
          head_conflict = 1'b1;
        if (!direct[p] && !pop_port_found) begin
          pop_port_found = 1'b1;
          pop_port       = p;
        end
      end
      if (!empty && pop_port_found && !head_conflict) begin
        pop          = 1'b1;
        we[pop_port] = 1'b1;
        wa[pop_port] = head_entry.index;
        wv[pop_port] = head_entry.entry;
      end

      if (loser_found) begin
        if (!full || pop) push = 1'b1;
        else              drop_n = drop_n + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    queue <= queue_next;
    if (push) queue[tail] <= push_data;
  end

  assign drop_sum = {1'b0, drop_count} + 17'(drop_n);

  always_ff @(posedge clk) begin
    if (!rst_n) drop_count <= '0;
    else        drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
  end

  assign bus.ramWe = we;
  assign bus.ramWa = wa;
  assign bus.ramWv = wv;

  assign initDone  = rst_n && (state == ST_RUN);
  assign queueFull = rst_n && full;
  assign dropCount = rst_n ? drop_count : '0;

endmodule

// File: tb/tb_btb_write_scheduler.sv
// Bench for btb_write_scheduler (ENTRY_NUM=16, 2 ports, 2 banks, 4-deep queue):
// RUN-mode RAM writes are checked against an expected-write queue.
module tb_btb_write_scheduler;
  import btb_write_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flushReq;
  logic        initDone;
  logic        queueFull;
  logic [15:0] dropCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    AXBTB_IndexPath idx;
    AXBTB_Entry     data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_en = 1'b0;

  btb_write_scheduler_if #(.WRITE_NUM(2)) bus ();

  btb_write_scheduler #(
    .ENTRY_NUM   (16),
    .WRITE_NUM   (2),
    .BANK_NUM    (2),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .flushReq  (flushReq),
    .initDone  (initDone),
    .queueFull (queueFull),
    .dropCount (dropCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        if (bus.ramWe[p]) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected port=%0d got idx=%0d data=%h expected no write",
                     p, bus.ramWa[p], bus.ramWv[p]);
          end else begin
            mon_e = exp_q.pop_front();
            if (bus.ramWa[p] !== mon_e.idx || bus.ramWv[p] !== mon_e.data) begin
              bad++;
              $display("FAIL sb_write port=%0d got idx=%0d data=%h expected idx=%0d data=%h",
                       p, bus.ramWa[p], bus.ramWv[p], mon_e.idx, mon_e.data);
            end
          end
        end
      end
    end
  end

  function automatic AXBTB_Entry mk(input logic [31:0] v);
    AXBTB_Entry e;
    e.valid  = 1'b1;
    e.tag    = v[31:16] ^ v[15:0];
    e.target = v;
    return e;
  endfunction

  task automatic drive(input logic v0, input int i0, input AXBTB_Entry d0,
                       input logic v1, input int i1, input AXBTB_Entry d1);
    @(posedge clk);
    #2;
    bus.reqValid    = {v1, v0};
    bus.reqIndex[0] = AXBTB_IndexPath'(i0);
    bus.reqEntry[0] = d0;
    bus.reqIndex[1] = AXBTB_IndexPath'(i1);
    bus.reqEntry[1] = d1;
  endtask

  task automatic expect_write(input int idx, input AXBTB_Entry d);
    exp_q.push_back('{idx: AXBTB_IndexPath'(idx), data: d});
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 4;
    if (bus.ramWe !== 2'b00) begin bad++; $display("FAIL rst_we got=%b exp=00", bus.ramWe); end
    if (initDone !== 1'b0) begin bad++; $display("FAIL rst_initdone got=%b exp=0", initDone); end
    if (queueFull !== 1'b0) begin bad++; $display("FAIL rst_qfull got=%b exp=0", queueFull); end
    if (dropCount !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", dropCount); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      if (c == 3) begin
        bus.reqValid    = 2'b11;
        bus.reqIndex[0] = AXBTB_IndexPath'(1);
        bus.reqIndex[1] = AXBTB_IndexPath'(3);
        bus.reqEntry[0] = mk(32'h1111_0001);
        bus.reqEntry[1] = mk(32'h1111_0002);
      end
      if (c == 6) bus.reqValid = 2'b00;
      @(negedge clk);
      total += 2;
      if (bus.ramWe !== 2'b01 || bus.ramWa[0] !== AXBTB_IndexPath'(c) || bus.ramWv[0] !== AXBTB_Entry'('0)) begin
        bad++;
        $display("FAIL init_sweep c=%0d got we=%b wa=%0d wv=%h exp we=01 wa=%0d wv=0",
                 c, bus.ramWe, bus.ramWa[0], bus.ramWv[0], c);
      end
      if (initDone !== 1'b0) begin bad++; $display("FAIL init_done_early c=%0d got=%b exp=0", c, initDone); end
    end
    @(posedge clk);
    #2 mon_en = 1'b1;
    @(negedge clk);
    total += 3;
    if (initDone !== 1'b1) begin bad++; $display("FAIL init_done got=%b exp=1", initDone); end
    if (bus.ramWe !== 2'b00) begin bad++; $display("FAIL run_idle_we got=%b exp=00", bus.ramWe); end
    if (dropCount !== 16'd0) begin bad++; $display("FAIL init_req_counted got=%0d exp=0", dropCount); end
  endtask

  task automatic test_no_conflict();
    AXBTB_Entry da = mk(32'hA000_0002);
    AXBTB_Entry db = mk(32'hB000_0005);
    drive(1'b1, 2, da, 1'b1, 5, db);
    expect_write(2, da);
    expect_write(5, db);
    @(negedge clk);
    total += 2;
    if (bus.ramWe !== 2'b11) begin bad++; $display("FAIL nc_we got=%b exp=11", bus.ramWe); end
    if (queueFull !== 1'b0) begin bad++; $display("FAIL nc_qfull got=%b exp=0", queueFull); end
    drive(1'b0, 0, '0, 1'b0, 0, '0);
    @(negedge clk);
    total += 2;
    if (bus.ramWe !== 2'b00) begin bad++; $display("FAIL nc_idle_we got=%b exp=00", bus.ramWe); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL nc_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_bank_conflict();
    AXBTB_Entry dc = mk(32'hC000_0002);
    AXBTB_Entry dd = mk(32'hD000_0004);
    drive(1'b1, 2, dc, 1'b1, 4, dd);
    expect_write(2, dc);
    @(negedge clk);
    total++;
    if (bus.ramWe !== 2'b01) begin bad++; $display("FAIL bc_direct_we got=%b exp=01", bus.ramWe); end
    drive(1'b0, 0, '0, 1'b0, 0, '0);
    expect_write(4, dd);
    @(negedge clk);
    total++;
    if (bus.ramWe !== 2'b01) begin bad++; $display("FAIL bc_pop_we got=%b exp=01", bus.ramWe); end
    drive(1'b0, 0, '0, 1'b0, 0, '0);
    @(negedge clk);
    total += 2;
    if (bus.ramWe !== 2'b00) begin bad++; $display("FAIL bc_idle_we got=%b exp=00", bus.ramWe); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL bc_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_fill_drop();
    AXBTB_Entry pd [5];
    for (int k = 0; k < 5; k++) pd[k] = mk(32'hE000_0000 + 32'(k));
    for (int k = 0; k < 5; k++) begin
      AXBTB_Entry z = mk(32'h5000_0000 + 32'(k));
      drive(1'b1, 0, z, 1'b1, 2 * k + 2, pd[k]);
      expect_write(0, z);
      @(negedge clk);
      total += 2;
      if (bus.ramWe !== 2'b01) begin bad++; $display("FAIL fill_we k=%0d got=%b exp=01", k, bus.ramWe); end
      if (queueFull !== (k == 4)) begin bad++; $display("FAIL fill_qfull k=%0d got=%b exp=%b", k, queueFull, k == 4); end
    end
    drive(1'b0, 0, '0, 1'b0, 0, '0);
    expect_write(2, pd[0]);
    @(negedge clk);
    total += 2;
    if (dropCount !== 16'd1) begin bad++; $display("FAIL fill_drop got=%0d exp=1", dropCount); end
    if (queueFull !== 1'b1) begin bad++; $display("FAIL fill_full_hold got=%b exp=1", queueFull); end
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 0, '0, 1'b0, 0, '0);
      expect_write(2 * k + 2, pd[k]);
      @(negedge clk);
      total++;
      if (queueFull !== 1'b0) begin bad++; $display("FAIL drain_qfull k=%0d got=%b exp=0", k, queueFull); end
    end
    drive(1'b0, 0, '0, 1'b0, 0, '0);
    @(negedge clk);
    total += 3;
    if (bus.ramWe !== 2'b00) begin bad++; $display("FAIL drain_idle_we got=%b exp=00", bus.ramWe); end
    if (dropCount !== 16'd1) begin bad++; $display("FAIL drain_drop got=%0d exp=1", dropCount); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL fill_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_coalesce();
    AXBTB_Entry z = mk(32'h7000_0000);
    AXBTB_Entry x = mk(32'h7000_0A0A);
    AXBTB_Entry y = mk(32'h7000_0B0B);
    drive(1'b1, 0, z, 1'b1, 6, x);
    expect_write(0, z);
    @(negedge clk);
    total++;
    if (bus.ramWe !== 2'b01) begin bad++; $display("FAIL co_first_we got=%b exp=01", bus.ramWe); end
    drive(1'b1, 6, y, 1'b0, 0, '0);
    expect_write(6, y);
    @(negedge clk);
    drive(1'b0, 0, '0, 1'b0, 0, '0);
    @(negedge clk);
    total += 2;
    if (bus.ramWe !== 2'b00) begin bad++; $display("FAIL co_idle_we got=%b exp=00", bus.ramWe); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL co_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_flush();
    AXBTB_Entry z = mk(32'h9000_0000);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 0, z, 1'b1, 2 * k + 2, mk(32'h9100_0000 + 32'(k)));
      expect_write(0, z);
      @(negedge clk);
    end
    drive(1'b0, 0, '0, 1'b0, 0, '0);
    flushReq = 1'b1;
    mon_en   = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ramWe !== 2'b00) begin bad++; $display("FAIL flush_cycle_we got=%b exp=00", bus.ramWe); end
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #2 flushReq = (c == 4);
      @(negedge clk);
      total += 2;
      if (bus.ramWe !== 2'b01 || bus.ramWa[0] !== AXBTB_IndexPath'(c) || bus.ramWv[0].valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_sweep c=%0d got we=%b wa=%0d valid=%b exp we=01 wa=%0d valid=0",
                 c, bus.ramWe, bus.ramWa[0], bus.ramWv[0].valid, c);
      end
      if (initDone !== 1'b0 || queueFull !== 1'b0) begin
        bad++;
        $display("FAIL flush_status c=%0d got done=%b full=%b exp done=0 full=0", c, initDone, queueFull);
      end
    end
    @(posedge clk);
    #2 begin flushReq = 1'b0; mon_en = 1'b1; end
    @(negedge clk);
    total++;
    if (initDone !== 1'b1) begin bad++; $display("FAIL flush_done got=%b exp=1", initDone); end
    repeat (4) drive(1'b0, 0, '0, 1'b0, 0, '0);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL flush_pending got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst_n        = 1'b0;
    flushReq     = 1'b0;
    bus.reqValid = '0;
    for (int p = 0; p < 2; p++) begin
      bus.reqIndex[p] = '0;
      bus.reqEntry[p] = '0;
    end
    test_reset();
    test_no_conflict();
    test_bank_conflict();
    test_fill_drop();
    test_coalesce();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
